// File: rtl/exu_div_arb_ctl_pkg.sv
// Shared types and constants for the divider arbiter/sequencer.
package exu_div_arb_ctl_pkg;

    localparam int unsigned DIV_MBPTA_LATENCY = 36;
    localparam int unsigned DATA_W            = 32;

    // Sequencer states
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // Operation payload presented to the divider
    typedef struct packed {
        logic [DATA_W-1:0] dividend;
        logic [DATA_W-1:0] divisor;
        logic              unsign;
        logic              rem;
    } div_pkt_t;

endpackage

// File: rtl/exu_div_arb_ctl_if.sv
// Request, divider and response bundle between issue logic, arbiter and divider.
interface exu_div_arb_ctl_if;
    import exu_div_arb_ctl_pkg::*;

    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0][DATA_W-1:0] req_dividend;
    logic [1:0][DATA_W-1:0] req_divisor;
    logic [1:0]             req_unsign;
    logic [1:0]             req_rem;
    logic [1:0]             req_flush;
    logic                   div_valid;
    logic [DATA_W-1:0]      div_dividend;
    logic [DATA_W-1:0]      div_divisor;
    logic                   div_unsign;
    logic                   div_rem;
    logic                   div_cancel;
    logic                   div_finish;
    logic [DATA_W-1:0]      div_result;
    logic [1:0]             rsp_valid;
    logic [DATA_W-1:0]      rsp_data;
    logic [1:0]             rsp_ready;
    logic                   busy;
    logic                   err_latency;

    // Arbiter side
    modport slave (
        input  req_valid, req_dividend, req_divisor, req_unsign, req_rem, req_flush,
        input  div_finish, div_result, rsp_ready,
        output req_ready, div_valid, div_dividend, div_divisor, div_unsign, div_rem,
        output div_cancel, rsp_valid, rsp_data, busy, err_latency
    );

    // Requester/divider side
    modport master (
        output req_valid, req_dividend, req_divisor, req_unsign, req_rem, req_flush,
        output div_finish, div_result, rsp_ready,
        input  req_ready, div_valid, div_dividend, div_divisor, div_unsign, div_rem,
        input  div_cancel, rsp_valid, rsp_data, busy, err_latency
    );

endinterface

// File: rtl/exu_div_rr_arb.sv
// Two-way round-robin grant; the pointer moves past the winner on each accepted grant.
module exu_div_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    output logic [1:0] o_gnt_c
);

    logic r_ptr;
    logic w_pick;

    // Preferred requester wins if asking, otherwise the other one
    always_comb begin
        w_pick  = i_req[r_ptr] ? r_ptr : ~r_ptr;
        o_gnt_c = 2'b00;
        if (|i_req) begin
            o_gnt_c[w_pick] = 1'b1;
        end
    end

    // Pointer update on accepted grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_upd) begin
            r_ptr <= ~w_pick;
        end
    end

endmodule

// File: rtl/exu_div_arb_ctl.sv
// Shares one constant-latency divider between two requesters; results are
// released a fixed number of cycles after issue regardless of divider timing.
module exu_div_arb_ctl
    import exu_div_arb_ctl_pkg::*;
#(
    parameter int unsigned DIV_LATENCY   = DIV_MBPTA_LATENCY,
    parameter int unsigned TIMEOUT_SLACK = 3
) (
    input  logic              clk,
    input  logic              rst,
    exu_div_arb_ctl_if.slave  bus
);

    localparam int unsigned     CNT_W   = $clog2(DIV_LATENCY + TIMEOUT_SLACK + 1);
    localparam logic [CNT_W-1:0] CNT_LAT = CNT_W'(DIV_LATENCY);
    localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(DIV_LATENCY + TIMEOUT_SLACK);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_owner;
    logic              r_res_ok;
    logic              r_div_valid;
    logic [1:0]        r_rsp_valid;
    logic [DATA_W-1:0] r_res;
    div_pkt_t          r_pkt;
    div_pkt_t          w_pkt;
    logic [1:0]        w_arb_req;
    logic [1:0]        w_gnt;
    logic              w_hs;
    logic              w_sel;
    logic              w_own_flush;
    logic              w_active;
    logic              w_err;
    logic              w_capture;

    // Only flush-free requesters compete, and only while idle
    assign w_arb_req   = (r_state == S_IDLE && !rst) ? (bus.req_valid & ~bus.req_flush) : 2'b00;
    assign w_hs        = |w_gnt;
    assign w_sel       = w_gnt[1];
    assign w_own_flush = bus.req_flush[r_owner];
    assign w_active    = (r_state == S_ISSUE) || (r_state == S_WAIT);

    exu_div_rr_arb u_rr_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req   (w_arb_req),
        .i_upd   (w_hs),
        .o_gnt_c (w_gnt)
    );

    // Operand mux for the granted requester
    always_comb begin
        w_pkt.dividend = bus.req_dividend[w_sel];
        w_pkt.divisor  = bus.req_divisor[w_sel];
        w_pkt.unsign   = bus.req_unsign[w_sel];
        w_pkt.rem      = bus.req_rem[w_sel];
    end

    // Next state, result capture and latency-error detection
    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hs) w_state_nxt = S_ISSUE;
                w_err = bus.div_finish;
            end
            S_ISSUE: begin
                w_state_nxt = w_own_flush ? S_IDLE : S_WAIT;
                w_err       = bus.div_finish;
            end
            S_WAIT: begin
                if (w_own_flush) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_capture = bus.div_finish;
                    // Release is padded to the fixed latency even for an early finish
                    if (r_cnt >= CNT_LAT && (r_res_ok || bus.div_finish)) begin
                        w_state_nxt = S_RESP;
                    end else if (r_cnt == CNT_TMO) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_RESP: begin
                if (w_own_flush || bus.rsp_ready[r_owner]) w_state_nxt = S_IDLE;
                w_err = bus.div_finish;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, counter, operand and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_owner     <= 1'b0;
            r_res_ok    <= 1'b0;
            r_div_valid <= 1'b0;
            r_rsp_valid <= 2'b00;
            r_res       <= '0;
            r_pkt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= (w_state_nxt == S_WAIT) ? r_cnt + CNT_W'(1) : '0;
            r_div_valid <= w_hs;
            r_rsp_valid <= (w_state_nxt == S_RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
            if (w_hs) begin
                r_owner <= w_sel;
                r_pkt   <= w_pkt;
            end
            if (w_hs || w_state_nxt == S_IDLE) begin
                r_res_ok <= 1'b0;
            end else if (w_capture) begin
                r_res_ok <= 1'b1;
            end
            if (w_capture) r_res <= bus.div_result;
        end
    end

    assign bus.req_ready    = w_gnt;
    assign bus.div_valid    = r_div_valid;
    assign bus.div_dividend = r_pkt.dividend;
    assign bus.div_divisor  = r_pkt.divisor;
    assign bus.div_unsign   = r_pkt.unsign;
    assign bus.div_rem      = r_pkt.rem;
    assign bus.div_cancel   = rst | (w_active & w_own_flush);
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_data     = r_res;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.err_latency  = w_err & ~rst;

endmodule

// File: tb/tb_exu_div_arb_ctl.sv
// Directed bench for the shared-divider arbiter/sequencer.
module tb_exu_div_arb_ctl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exu_div_arb_ctl_if bus ();

    exu_div_arb_ctl #(.DIV_LATENCY(36), .TIMEOUT_SLACK(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  gnt;
        logic [31:0] a;
        logic [31:0] b;
        logic        uns;
        logic        rem;
        int          fin;     // cnt at which div_finish arrives, -1 = never
        logic [31:0] res;
        int          rsp_k;   // cycles after accept to rsp_valid, -1 = none
        int          err_k;   // cycles after accept to err_latency, -1 = none
        logic [31:0] data;
    } vec_t;

    vec_t        vecs [5];
    int          n_vec = 0;
    int          n_err = 0;
    int          rk, ek;
    logic [31:0] d;
    logic [1:0]  rv;
    logic [1:0]  seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request, check the grant, then check the issued operands
    task automatic accept(input logic [1:0] valid, input logic [1:0] exp_gnt, input logic clr,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic uns, input logic rem, input string tag);
        int r;
        r = exp_gnt[1] ? 1 : 0;
        bus.req_dividend[r]   = a;
        bus.req_divisor[r]    = b;
        bus.req_unsign[r]     = uns;
        bus.req_rem[r]        = rem;
        bus.req_dividend[1-r] = ~a;
        bus.req_divisor[1-r]  = ~b;
        bus.req_unsign[1-r]   = ~uns;
        bus.req_rem[1-r]      = ~rem;
        bus.req_valid         = valid;
        #3;
        chk({tag, " grant"}, 64'(bus.req_ready), 64'(exp_gnt));
        step();
        if (clr) bus.req_valid = 2'b00;
        #3;
        chk({tag, " div_valid"}, 64'(bus.div_valid), 64'(1));
        chk({tag, " div_dividend"}, 64'(bus.div_dividend), 64'(a));
        chk({tag, " div_divisor"}, 64'(bus.div_divisor), 64'(b));
        chk({tag, " div_type"}, 64'({bus.div_unsign, bus.div_rem}), 64'({uns, rem}));
    endtask

    // Play the divider from the issue cycle on; handshake the response when it shows
    task automatic finish_op(input int fin, input logic [31:0] res, input logic [1:0] own,
                             output int rsp_k, output int err_k,
                             output logic [31:0] data, output logic [1:0] rvec);
        rsp_k = -1;
        err_k = -1;
        data  = '0;
        rvec  = 2'b00;
        for (int k = 1; k <= 46; k++) begin
            bus.div_finish = (k == fin + 1);
            bus.div_result = (k == fin + 1) ? res : 32'h0;
            @(negedge clk);
            if (bus.err_latency && err_k < 0) err_k = k;
            if (bus.rsp_valid != 2'b00 && rsp_k < 0) begin
                rsp_k         = k;
                data          = bus.rsp_data;
                rvec          = bus.rsp_valid;
                bus.rsp_ready = own;
            end
            step();
            bus.rsp_ready = 2'b00;
            if (rsp_k >= 0) break;
        end
        bus.div_finish = 1'b0;
        bus.div_result = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected summary before timeout");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{2'b01, 2'b01, 32'd100,        32'd7,  1'b0, 1'b0, 36, 32'd14,        38, -1, 32'd14};
        vecs[1] = '{2'b10, 2'b10, 32'hFFFF_FF9C,  32'd7,  1'b0, 1'b1,  5, 32'hFFFF_FFFE, 38, -1, 32'hFFFF_FFFE};
        vecs[2] = '{2'b01, 2'b01, 32'd55,         32'd0,  1'b1, 1'b0, -1, 32'd0,         -1, 40, 32'd0};
        vecs[3] = '{2'b10, 2'b10, 32'd1000,       32'd10, 1'b1, 1'b0, 36, 32'd100,       38, -1, 32'd100};
        vecs[4] = '{2'b01, 2'b01, 32'h8000_0000,  32'd3,  1'b1, 1'b1, 20, 32'd2,         38, -1, 32'd2};

        bus.req_valid    = '0;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        bus.req_unsign   = '0;
        bus.req_rem      = '0;
        bus.req_flush    = '0;
        bus.div_finish   = 1'b0;
        bus.div_result   = '0;
        bus.rsp_ready    = '0;
        rst              = 1'b1;

        // Reset cycle: cancel asserted, no grant even with a request pending
        step();
        bus.req_valid = 2'b01;
        #3;
        chk("rst div_cancel", 64'(bus.div_cancel), 64'(1));
        chk("rst req_ready", 64'(bus.req_ready), 64'(0));
        chk("rst err_latency", 64'(bus.err_latency), 64'(0));
        step();
        rst           = 1'b0;
        bus.req_valid = 2'b00;
        #3;
        chk("reset busy", 64'(bus.busy), 64'(0));
        chk("reset div_valid", 64'(bus.div_valid), 64'(0));
        chk("reset div_cancel", 64'(bus.div_cancel), 64'(0));
        chk("reset rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("reset div_dividend", 64'(bus.div_dividend), 64'(0));
        chk("reset rsp_data", 64'(bus.rsp_data), 64'(0));

        // Table of single-requester operations
        step();
        for (int i = 0; i < 5; i++) begin
            accept(vecs[i].valid, vecs[i].gnt, 1'b1, vecs[i].a, vecs[i].b,
                   vecs[i].uns, vecs[i].rem, $sformatf("vec%0d", i));
            finish_op(vecs[i].fin, vecs[i].res, vecs[i].gnt, rk, ek, d, rv);
            chk($sformatf("vec%0d rsp latency", i), 64'(rk), 64'(vecs[i].rsp_k));
            chk($sformatf("vec%0d err latency", i), 64'(ek), 64'(vecs[i].err_k));
            chk($sformatf("vec%0d rsp_data", i), 64'(d), 64'(vecs[i].data));
            chk($sformatf("vec%0d rsp owner", i), 64'(rv),
                64'((vecs[i].rsp_k >= 0) ? vecs[i].gnt : 2'b00));
            #3;
            chk($sformatf("vec%0d idle", i), 64'(bus.busy), 64'(0));
        end

        // Both requesters valid from reset: grants alternate starting with req0
        rst           = 1'b1;
        bus.req_valid = 2'b11;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            accept(2'b11, (i % 2 == 1) ? 2'b10 : 2'b01, 1'b0, 32'h100 + 32'(i), 32'd3,
                   1'b0, 1'b0, $sformatf("rr%0d", i));
            finish_op(36, 32'h55 + 32'(i), (i % 2 == 1) ? 2'b10 : 2'b01, rk, ek, d, rv);
            chk($sformatf("rr%0d rsp latency", i), 64'(rk), 64'(38));
            chk($sformatf("rr%0d rsp owner", i), 64'(rv), 64'((i % 2 == 1) ? 2'b10 : 2'b01));
        end
        bus.req_valid = 2'b00;

        // Flush: non-owner has no effect, owner at cnt=10 cancels
        accept(2'b01, 2'b01, 1'b1, 32'd77, 32'd5, 1'b0, 1'b0, "flush");
        repeat (4) step();
        bus.req_flush = 2'b10;
        #3;
        chk("nonowner flush cancel", 64'(bus.div_cancel), 64'(0));
        step();
        bus.req_flush = 2'b00;
        #3;
        chk("nonowner flush busy", 64'(bus.busy), 64'(1));
        repeat (5) step();
        bus.req_flush = 2'b01;
        #3;
        chk("owner flush cancel", 64'(bus.div_cancel), 64'(1));
        step();
        bus.req_flush = 2'b00;
        #3;
        chk("owner flush busy", 64'(bus.busy), 64'(0));
        chk("owner flush cancel off", 64'(bus.div_cancel), 64'(0));
        seen = 2'b00;
        for (int i = 0; i < 40; i++) begin
            step();
            #3;
            seen = seen | bus.rsp_valid;
        end
        chk("flush no response", 64'(seen), 64'(0));

        // Flush of the owner while its response is pending drops it
        step();
        accept(2'b10, 2'b10, 1'b1, 32'd81, 32'd9, 1'b1, 1'b0, "rflush");
        repeat (36) step();
        bus.div_finish = 1'b1;
        bus.div_result = 32'd9;
        step();
        bus.div_finish = 1'b0;
        bus.div_result = '0;
        #3;
        chk("rflush rsp_valid", 64'(bus.rsp_valid), 64'(2'b10));
        chk("rflush rsp_data", 64'(bus.rsp_data), 64'(9));
        bus.req_flush = 2'b10;
        step();
        bus.req_flush = 2'b00;
        #3;
        chk("rflush dropped", 64'(bus.rsp_valid), 64'(0));
        chk("rflush idle", 64'(bus.busy), 64'(0));

        // Stray divider finish while idle
        step();
        bus.div_finish = 1'b1;
        #3;
        chk("stray finish err", 64'(bus.err_latency), 64'(1));
        step();
        bus.div_finish = 1'b0;
        #3;
        chk("stray finish err off", 64'(bus.err_latency), 64'(0));
        chk("stray finish busy", 64'(bus.busy), 64'(0));

        // Reset at cnt=20 with a new request right after
        step();
        accept(2'b01, 2'b01, 1'b1, 32'h1234, 32'h56, 1'b1, 1'b1, "rstop");
        repeat (20) step();
        rst = 1'b1;
        #3;
        chk("midrst div_cancel", 64'(bus.div_cancel), 64'(1));
        chk("midrst err", 64'(bus.err_latency), 64'(0));
        chk("midrst req_ready", 64'(bus.req_ready), 64'(0));
        step();
        rst = 1'b0;
        #3;
        chk("postrst busy", 64'(bus.busy), 64'(0));
        chk("postrst div_valid", 64'(bus.div_valid), 64'(0));
        chk("postrst div_cancel", 64'(bus.div_cancel), 64'(0));
        chk("postrst rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("postrst div_dividend", 64'(bus.div_dividend), 64'(0));
        chk("postrst div_divisor", 64'(bus.div_divisor), 64'(0));
        chk("postrst div_type", 64'({bus.div_unsign, bus.div_rem}), 64'(0));
        chk("postrst rsp_data", 64'(bus.rsp_data), 64'(0));
        accept(2'b11, 2'b01, 1'b1, 32'd200, 32'd20, 1'b0, 1'b0, "postrst");
        finish_op(36, 32'd10, 2'b01, rk, ek, d, rv);
        chk("postrst rsp latency", 64'(rk), 64'(38));
        chk("postrst rsp_data", 64'(d), 64'(10));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
